// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with clamped parallel load, wrap/saturate
// mode and registered terminal-count and load-error pulses.
module bcd_updown_counter #(
    parameter int unsigned DIGITS = 2,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up_dn,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] q,
    output logic                tc,
    output logic                load_err
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] load_q;
    logic         load_bad;
    logic [W-1:0] step_q;
    logic [W-1:0] count_q;
    logic         boundary;
    logic         carry;
    logic [3:0]   ld;
    logic [3:0]   cd;

    // Per-digit clamp of the load value and a rippling carry/borrow step.
    // A carry/borrow surviving past the top digit marks a range boundary.
    always_comb begin
        load_q   = '0;
        load_bad = 1'b0;
        step_q   = '0;
        carry    = 1'b1;
        ld       = '0;
        cd       = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            ld = load_val[4*i +: 4];
            if (ld > 4'd9) begin
                load_q[4*i +: 4] = 4'd9;
                load_bad         = 1'b1;
            end else begin
                load_q[4*i +: 4] = ld;
            end

            cd = q[4*i +: 4];
            if (!carry) begin
                step_q[4*i +: 4] = cd;
            end else if (up_dn) begin
                if (cd == 4'd9) begin
                    step_q[4*i +: 4] = 4'd0;
                end else begin
                    step_q[4*i +: 4] = cd + 4'd1;
                    carry            = 1'b0;
                end
            end else begin
                if (cd == 4'd0) begin
                    step_q[4*i +: 4] = 4'd9;
                end else begin
                    step_q[4*i +: 4] = cd - 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        boundary = carry;
        count_q  = (boundary && !WRAP) ? q : step_q;
    end

    // Priority: load > en > hold; tc and load_err are single-edge pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q        <= '0;
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            q        <= load_q;
            tc       <= 1'b0;
            load_err <= load_bad;
        end else if (en) begin
            q        <= count_q;
            tc       <= boundary;
            load_err <= 1'b0;
        end else begin
            tc       <= 1'b0;
            load_err <= 1'b0;
        end
    end

endmodule
